mcu_clk_rst_gen: RTL and testbench
==================================

# mcu_clk_rst_gen

Parametrised clock-enable and reset sequencer for the MCU51 core. It runs from the single fast board clock and derives three timing signals: an oscillator-rate tick, a 12-phase machine-cycle tick with its phase index, and a square clock output. It also owns the core reset: power-on reset, and the external RST pin with minimum-width qualification and post-release stretching. It sits between the board pins and `top`, and replaces ad-hoc clock division and raw reset wiring.

## Interface
- `OSC_DIV`, 8: CLK cycles per oscillator tick (≥2).
- `MC_LEN`, 12: oscillator ticks per machine cycle (≥2).
- `REQ_MC`, 2: machine-cycle ticks `rst_req` must stay high before the core is reset (≥1).
- `HOLD_MC`, 4: machine-cycle ticks `cpu_rst` is held after the reset source goes away (≥1).
- `SYNC_STAGES`, 2: synchroniser depth on `rst_req` (≥2).

Ports:
- `CLK`  in  1  system clock; all state is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low power-on reset.
- `rst_req`  in  1  external RST pin, active-high, asynchronous to `CLK`.
- `osc_en`  out  1  one-CLK pulse per oscillator tick.
- `mc_en`  out  1  one-CLK pulse per machine cycle; always coincides with `osc_en`.
- `phase`  out  $clog2(MC_LEN)  oscillator-tick index within the machine cycle.
- `clk_out`  out  1  square wave with period 2·OSC_DIV CLKs (the MHz12 pin).
- `cpu_rst`  out  1  active-high core reset.
- `rst_cause`  out  2  last reset source: 01 power-on, 10 pin. 00 and 11 are never produced.

## Operation
- **Values while `reset_n` is low:**
  - `osc_cnt` = 0, `phase` = 0, `clk_out` = 0.
  - `osc_en` = 0, `mc_en` = 0.
  - Synchroniser flops = 0.
  - `cpu_rst` = 1, `rst_cause` = 01.
  - State = HOLD, `mc_cnt` = 0.
- **Divider chain:**
  - `osc_cnt` counts 0..OSC_DIV-1 and wraps.
  - `osc_en` = (`osc_cnt` == OSC_DIV-1), decoded from the registered counter.
  - `phase` increments on `osc_en` and wraps MC_LEN-1→0.
  - `mc_en` = `osc_en` && (`phase` == MC_LEN-1).
  - `clk_out` toggles on every `osc_en`.
  - The chain runs freely during `cpu_rst`; only `reset_n` stops it.
- **Pin path:** `rst_req` passes through SYNC_STAGES flops to give `req_s`. The FSM uses only `req_s`.
- **FSM transitions:**
  - **RUN** (`cpu_rst`=0): if `req_s`=1, go to ARM with `mc_cnt`=0.
  - **ARM** (`cpu_rst`=0):
    - If `req_s`=0, go to RUN (glitch rejected, `rst_cause` unchanged).
    - Otherwise count `mc_en`. When the REQ_MC-th `mc_en` arrives with `req_s`=1, go to RST and set `rst_cause`=10.
    - Effective qualification width is between REQ_MC-1 and REQ_MC machine cycles.
  - **RST** (`cpu_rst`=1): if `req_s`=0, go to HOLD with `mc_cnt`=0.
  - **HOLD** (`cpu_rst`=1):
    - Count `mc_en`. When the HOLD_MC-th `mc_en` arrives, go to RUN.
    - If `req_s`=1 in the same cycle, go to RST instead; the pin wins.
- **Outputs:**
  - `cpu_rst` is registered and equals 1 in RST and HOLD.
  - `rst_cause` is sticky until the next qualified reset.
  - A pin reset arriving during power-on HOLD overwrites `rst_cause` to 10 only when ARM completes. ARM is entered only from RUN, so a pin held across power-on HOLD goes to RST directly and keeps `rst_cause`=01.
- **Counter width:** `mc_cnt` is $clog2(max(REQ_MC,HOLD_MC)+1) bits and saturates; it never wraps.

## Timing
- CLK cycles are indexed from 0, where cycle 0 is the first CLK rising edge after `reset_n` is released.
- `osc_en` is high in cycles OSC_DIV-1, 2·OSC_DIV-1, and so on.
- `mc_en` is high in cycles k·MC_LEN·OSC_DIV-1.
- `cpu_rst` after power-on: first low cycle is HOLD_MC·MC_LEN·OSC_DIV. With the defaults that is cycle 384.
- Pin assertion latency: SYNC_STAGES CLKs from `rst_req` to `req_s`, plus one CLK to register `cpu_rst`.
- Pin release: `cpu_rst` falls one CLK after the HOLD_MC-th `mc_en` that follows `req_s` falling.
- `reset_n` asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge.

## Structure
- Package `mcu_clk_rst_pkg`:
  - State enum: RUN, ARM, RST, HOLD.
  - Cause constants: `CAUSE_POR`=2'b01, `CAUSE_PIN`=2'b10.
- Sub-module `bit_sync` (parameter STAGES, async active-low clear), used for `rst_req`.
- The divider chain and FSM stay in the top-level module.

## Test plan
- **Power-on:** release `reset_n`, defaults.
  - `osc_en` high in cycles 7 and 15.
  - `mc_en` high in cycle 95.
  - `clk_out` period 16.
  - `cpu_rst` falls at cycle 384; `rst_cause`=01.
- **Glitch reject:** pulse `rst_req` for 40 CLKs, starting right after an `mc_en`.
  - `cpu_rst` stays 0; `rst_cause` stays 01.
- **Qualified pin reset:** hold `rst_req` for 300 CLKs.
  - `cpu_rst` rises one CLK after the second `mc_en` seen with `req_s`=1.
  - `rst_cause`=10.
  - `cpu_rst` falls one CLK after the 4th `mc_en` following `req_s` falling.
- **Re-assert in HOLD:** raise `rst_req` during HOLD after 2 `mc_en`s.
  - FSM returns to RST; `cpu_rst` stays 1 throughout.
  - Full HOLD_MC count restarts after the second release.
- **Async reset mid-operation:** pull `reset_n` low during ARM and during RST.
  - `cpu_rst`=1, `phase`=0, `clk_out`=0, `rst_cause`=01 immediately, with no CLK edge required.
- **Parameter sweep:** OSC_DIV=2, MC_LEN=2, REQ_MC=1, HOLD_MC=1.
  - `mc_en` period is 4 CLKs.
  - `cpu_rst` first low at cycle 4.
  - `osc_en` and `mc_en` remain coincident.

Source files
------------

// File: rtl/mcu_clk_rst_pkg.sv
// Shared types and constants for the MCU51 clock-enable and reset sequencer.
package mcu_clk_rst_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      ARM  = 2'b01,
      RST  = 2'b10,
      HOLD = 2'b11
   } rst_state_e;

   localparam logic [1:0] CAUSE_POR = 2'b01;
   localparam logic [1:0] CAUSE_PIN = 2'b10;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, cleared by an async active-low reset.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic clr_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // shift the raw input through the synchroniser chain
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mcu_clk_rst_gen.sv
// Clock-enable divider chain and core reset sequencer (power-on plus qualified, stretched RST pin).
module mcu_clk_rst_gen
   import mcu_clk_rst_pkg::*;
#(
   parameter int OSC_DIV     = 8,
   parameter int MC_LEN      = 12,
   parameter int REQ_MC      = 2,
   parameter int HOLD_MC     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      CLK,
   input  logic                      reset_n,
   input  logic                      rst_req,
   output logic                      osc_en,
   output logic                      mc_en,
   output logic [$clog2(MC_LEN)-1:0] phase,
   output logic                      clk_out,
   output logic                      cpu_rst,
   output logic [1:0]                rst_cause
);

   localparam int OSC_W   = $clog2(OSC_DIV);
   localparam int PH_W    = $clog2(MC_LEN);
   localparam int CNT_MAX = max_int(REQ_MC, HOLD_MC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [OSC_W-1:0] osc_cnt;
   logic             osc_pre;
   logic             osc_last;
   logic             req_s;
   rst_state_e       state;
   rst_state_e       state_nx;
   logic [CNT_W-1:0] mc_cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] cnt_inc;
   logic [1:0]       cause_nx;

   // osc_en/mc_en are registered one CLK early so they line up with the counter's last state
   assign osc_pre  = (osc_cnt == OSC_W'(OSC_DIV - 2));
   assign osc_last = (osc_cnt == OSC_W'(OSC_DIV - 1));
   assign cnt_inc  = (mc_cnt == CNT_W'(CNT_MAX)) ? mc_cnt : mc_cnt + 1'b1;

   // free-running divider chain, stopped only by reset_n
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         osc_cnt <= '0;
         osc_en  <= 1'b0;
         mc_en   <= 1'b0;
         phase   <= '0;
         clk_out <= 1'b0;
      end else begin
         osc_cnt <= osc_last ? '0 : osc_cnt + 1'b1;
         osc_en  <= osc_pre;
         mc_en   <= osc_pre && (phase == PH_W'(MC_LEN - 1));
         if (osc_en) begin
            phase   <= (phase == PH_W'(MC_LEN - 1)) ? '0 : phase + 1'b1;
            clk_out <= ~clk_out;
         end
      end
   end

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk   (CLK),
      .clr_n (reset_n),
      .d     (rst_req),
      .q     (req_s)
   );

   // reset sequencer next-state logic
   always_comb begin
      state_nx = state;
      cnt_nx   = mc_cnt;
      cause_nx = rst_cause;
      case (state)
         RUN: begin
            if (req_s) begin
               state_nx = ARM;
               cnt_nx   = '0;
            end else begin
               state_nx = RUN;
            end
         end
         ARM: begin
            if (!req_s) begin
               state_nx = RUN;
            end else if (mc_en) begin
               if (mc_cnt == CNT_W'(REQ_MC - 1)) begin
                  state_nx = RST;
                  cause_nx = CAUSE_PIN;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end else begin
               state_nx = ARM;
            end
         end
         RST: begin
            if (!req_s) begin
               state_nx = HOLD;
               cnt_nx   = '0;
            end else begin
               state_nx = RST;
            end
         end
         HOLD: begin
            // the pin wins if it is back when the stretch completes
            if (mc_en) begin
               if (mc_cnt == CNT_W'(HOLD_MC - 1)) begin
                  state_nx = req_s ? RST : RUN;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end else begin
               state_nx = HOLD;
            end
         end
         default: begin
            state_nx = HOLD;
            cnt_nx   = '0;
         end
      endcase
   end

   // sequencer state and registered reset outputs
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state     <= HOLD;
         mc_cnt    <= '0;
         cpu_rst   <= 1'b1;
         rst_cause <= CAUSE_POR;
      end else begin
         state     <= state_nx;
         mc_cnt    <= cnt_nx;
         cpu_rst   <= (state_nx == RST) || (state_nx == HOLD);
         rst_cause <= cause_nx;
      end
   end

endmodule

// File: tb/tb_mcu_clk_rst_gen.sv
// Directed, scoreboard-based bench for mcu_clk_rst_gen (default parameters plus a small-parameter instance).
module tb_mcu_clk_rst_gen;
   import mcu_clk_rst_pkg::*;

   localparam int MCP = 96;

   logic       CLK     = 1'b0;
   logic       reset_n = 1'b0;
   logic       rst_req = 1'b0;
   logic       rst_req2 = 1'b0;
   logic       osc_en, mc_en, clk_out, cpu_rst;
   logic [3:0] phase;
   logic [1:0] rst_cause;
   logic       osc_en2, mc_en2, clk_out2, cpu_rst2;
   logic [0:0] phase2;
   logic [1:0] rst_cause2;

   int cyc;
   int checks = 0;
   int passed = 0;

   typedef struct {
      string tag;
      int    exp;
   } sb_item_t;
   sb_item_t sb[$];

   mcu_clk_rst_gen dut (
      .CLK(CLK), .reset_n(reset_n), .rst_req(rst_req),
      .osc_en(osc_en), .mc_en(mc_en), .phase(phase), .clk_out(clk_out),
      .cpu_rst(cpu_rst), .rst_cause(rst_cause)
   );

   mcu_clk_rst_gen #(
      .OSC_DIV(2), .MC_LEN(2), .REQ_MC(1), .HOLD_MC(1), .SYNC_STAGES(2)
   ) dut2 (
      .CLK(CLK), .reset_n(reset_n), .rst_req(rst_req2),
      .osc_en(osc_en2), .mc_en(mc_en2), .phase(phase2), .clk_out(clk_out2),
      .cpu_rst(cpu_rst2), .rst_cause(rst_cause2)
   );

   always #5 CLK = ~CLK;

   // cyc equals the index of the next rising edge, so a value seen at a falling edge is "in cycle cyc"
   always @(posedge CLK or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   function automatic logic sig(input int id);
      case (id)
         0: return osc_en;
         1: return mc_en;
         2: return clk_out;
         3: return cpu_rst;
         4: return osc_en2;
         5: return mc_en2;
         6: return cpu_rst2;
         default: return 1'bx;
      endcase
   endfunction

   // first default-parameter mc_en cycle at or after cycle e
   function automatic int next_mc(input int e);
      return ((e + MCP) / MCP) * MCP - 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic push(input string tag, input int exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb.push_back(it);
   endtask

   task automatic pop_chk(input int obs);
      sb_item_t it;
      if (sb.size() > 0) it = sb.pop_front();
      else begin
         it.tag = "sb_underflow";
         it.exp = -999;
      end
      chk(it.tag, obs, it.exp);
   endtask

   task automatic wait_lvl(input int id, input logic lvl, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (sig(id) === lvl) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic check_reset_values(input string tag, input logic [1:0] prev_cause);
      chk({tag, "_cpu_rst"}, cpu_rst, 1);
      chk({tag, "_phase"}, phase, 0);
      chk({tag, "_clk_out"}, clk_out, 0);
      chk({tag, "_osc_en"}, osc_en, 0);
      chk({tag, "_cause"}, rst_cause, CAUSE_POR);
      chk({tag, "_cause_was"}, prev_cause, prev_cause);
   endtask

   initial begin
      int at, r1, r2, m, p2, rel, n, nmc, nmiss;
      logic [1:0] cause_before;

      repeat (3) @(negedge CLK);
      chk("por_osc_en", osc_en, 0);
      chk("por_mc_en", mc_en, 0);
      chk("por_phase", phase, 0);
      chk("por_clk_out", clk_out, 0);
      chk("por_cpu_rst", cpu_rst, 1);
      chk("por_cause", rst_cause, CAUSE_POR);

      // power-on timing
      reset_n = 1'b1;
      push("osc_en_first", 7);     wait_lvl(0, 1'b1, 50, at);  pop_chk(at);
      push("clk_out_rise", 8);     wait_lvl(2, 1'b1, 50, r1);  pop_chk(r1);
      push("osc_en_second", 15);   wait_lvl(0, 1'b1, 50, at);  pop_chk(at);
      wait_lvl(2, 1'b0, 50, at);
      wait_lvl(2, 1'b1, 50, r2);
      push("clk_out_period", 16);  pop_chk((r1 < 0 || r2 < 0) ? -1 : r2 - r1);
      push("mc_en_first", 95);     wait_lvl(1, 1'b1, 200, at); pop_chk(at);
      chk("phase_at_mc", phase, 11);
      chk("osc_at_mc", osc_en, 1);
      push("por_release", 384);    wait_lvl(3, 1'b0, 400, at); pop_chk(at);
      chk("por_release_cause", rst_cause, CAUSE_POR);

      // glitch shorter than a machine cycle is rejected
      wait_lvl(1, 1'b1, 200, m);
      rst_req = 1'b1;
      n = 0;
      push("glitch_rst_cycles", 0);
      for (int i = 0; i < 240; i++) begin
         @(negedge CLK);
         if (i == 39) rst_req = 1'b0;
         if (cpu_rst !== 1'b0) n++;
      end
      pop_chk(n);
      chk("glitch_cause", rst_cause, CAUSE_POR);

      // qualified pin reset held 300 CLKs
      wait_lvl(1, 1'b1, 200, m);
      rst_req = 1'b1;
      push("pin_rise", m + 2 * MCP + 1); wait_lvl(3, 1'b1, 400, at); pop_chk(at);
      chk("pin_cause", rst_cause, CAUSE_PIN);
      while (cyc < m + 300) @(negedge CLK);
      rst_req = 1'b0;
      rel = cyc;
      push("pin_release", next_mc(rel + 3) + 3 * MCP + 1); wait_lvl(3, 1'b0, 800, at); pop_chk(at);

      // re-assert during HOLD after two stretch ticks
      wait_lvl(1, 1'b1, 200, m);
      rst_req = 1'b1;
      push("pin_rise_b", m + 2 * MCP + 1); wait_lvl(3, 1'b1, 400, at); pop_chk(at);
      while (cyc < m + 300) @(negedge CLK);
      rst_req = 1'b0;
      wait_lvl(1, 1'b1, 200, at);
      wait_lvl(1, 1'b1, 200, p2);
      chk("hold_before_reassert", cpu_rst, 1);
      rst_req = 1'b1;
      n = 0;
      push("reassert_low_cycles", 0);
      while (cyc < p2 + 250) begin
         @(negedge CLK);
         if (cpu_rst !== 1'b1) n++;
      end
      pop_chk(n);
      rst_req = 1'b0;
      rel = cyc;
      push("reassert_release", next_mc(rel + 3) + 3 * MCP + 1); wait_lvl(3, 1'b0, 1200, at); pop_chk(at);
      chk("reassert_cause", rst_cause, CAUSE_PIN);

      // async reset while in ARM
      wait_lvl(1, 1'b1, 200, m);
      rst_req = 1'b1;
      repeat (20) @(negedge CLK);
      chk("arm_phase_live", phase, 2);
      cause_before = rst_cause;
      #2 reset_n = 1'b0;
      #1 check_reset_values("arm_async", cause_before);
      chk("arm_cause_before", cause_before, CAUSE_PIN);
      rst_req = 1'b0;
      @(negedge CLK) reset_n = 1'b1;
      push("por_release_b", 384); wait_lvl(3, 1'b0, 400, at); pop_chk(at);

      // async reset while in RST, pin then held across power-on stretch
      wait_lvl(1, 1'b1, 200, m);
      rst_req = 1'b1;
      push("pin_rise_c", m + 2 * MCP + 1); wait_lvl(3, 1'b1, 400, at); pop_chk(at);
      repeat (10) @(negedge CLK);
      cause_before = rst_cause;
      #2 reset_n = 1'b0;
      #1 check_reset_values("rst_async", cause_before);
      chk("rst_cause_before", cause_before, CAUSE_PIN);
      @(negedge CLK) reset_n = 1'b1;
      while (cyc < 450) @(negedge CLK);
      rst_req = 1'b0;
      rel = cyc;
      push("por_pin_release", next_mc(rel + 3) + 3 * MCP + 1); wait_lvl(3, 1'b0, 1000, at); pop_chk(at);
      chk("por_pin_cause", rst_cause, CAUSE_POR);

      // small-parameter instance
      @(negedge CLK) reset_n = 1'b0;
      repeat (2) @(negedge CLK);
      reset_n = 1'b1;
      push("sweep_release", 4);   wait_lvl(6, 1'b0, 20, at); pop_chk(at);
      push("sweep_mc_next", 7);   wait_lvl(5, 1'b1, 20, r1); pop_chk(r1);
      wait_lvl(5, 1'b1, 20, r2);
      push("sweep_mc_period", 4); pop_chk((r1 < 0 || r2 < 0) ? -1 : r2 - r1);
      nmc = 0;
      nmiss = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (mc_en2 === 1'b1) nmc++;
         if (mc_en2 === 1'b1 && osc_en2 !== 1'b1) nmiss++;
      end
      push("sweep_mc_count", 10);      pop_chk(nmc);
      push("sweep_coincide_miss", 0);  pop_chk(nmiss);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
